// File: rtl/cos_engine_arbiter.sv
// ---------------------------------------------------------------------------
// cos_engine_arbiter
//
// Shares one pipelined cosine engine among NUM_REQ requesters. Each cycle at
// most one angle is issued, chosen round-robin among requesters that have a
// request and no operation already in flight or buffered. The requester ID
// travels alongside the engine in a LATENCY-deep tag pipeline. When the tag
// leaves the pipeline, the engine result is written into that requester's
// one-entry response buffer. eng_clk_en is high only while an operation is
// being issued or still has to advance through the engine.
//
// Optional build macro: COS_ARB_STATS_EN adds the stat_issued and stat_stall
// counters and their output ports.
//
// Ports:
//   clk          in   1            clock
//   reset        in   1            synchronous, active-high reset
//   req_valid    in   NUM_REQ      request present, per requester
//   req_angle    in   32*NUM_REQ   float32 angle, slice i = requester i
//   req_ready    out  NUM_REQ      request accepted this cycle (one-hot/zero)
//   resp_valid   out  NUM_REQ      response buffer i holds a result
//   resp_data    out  32*NUM_REQ   float32 cosine, slice i
//   resp_ready   in   NUM_REQ      requester i consumes its response
//   eng_clk_en   out  1            engine clock enable
//   eng_angle    out  32           angle to engine (combinational from grant)
//   eng_result   in   32           engine result
//   stat_issued  out  32           grants issued   (COS_ARB_STATS_EN only)
//   stat_stall   out  32           stalled cycles  (COS_ARB_STATS_EN only)
//   busy         out  1            any requester outstanding
// ---------------------------------------------------------------------------
module cos_engine_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_angle,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [32*NUM_REQ-1:0] resp_data,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic                  eng_clk_en,
  output logic [31:0]           eng_angle,
  input  logic [31:0]           eng_result,
`ifdef COS_ARB_STATS_EN
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_stall,
`endif
  output logic                  busy
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0]           r_outstanding;
  logic [NUM_REQ-1:0]           r_resp_valid;
  logic [NUM_REQ-1:0][31:0]     r_resp_data;
  logic [ID_W-1:0]              r_ptr;
  logic [LATENCY-1:0]           r_stg_vld;
  logic [LATENCY-1:0][ID_W-1:0] r_stg_id;

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0][31:0]     w_angles;
  logic [NUM_REQ-1:0]           w_elig;
  logic [NUM_REQ-1:0]           w_grant;
  logic [ID_W-1:0]              w_grant_id;
  logic                         w_issue;
  logic                         w_upstream;
  logic                         w_done;
  logic [ID_W-1:0]              w_done_id;
  logic [NUM_REQ-1:0]           w_complete;
  logic [NUM_REQ-1:0]           w_consume;

  assign w_angles  = req_angle;
  assign w_elig    = req_valid & ~r_outstanding;
  assign w_consume = r_resp_valid & resp_ready;
  assign w_done    = r_stg_vld[LATENCY-1];
  assign w_done_id = r_stg_id[LATENCY-1];

  // Round-robin scan starting at r_ptr; the first eligible index wins.
  // Nothing is granted while reset is asserted.
  always_comb begin
    // NOTE: every signal driven here gets a default before any condition so
    // no path leaves it unassigned, which would otherwise infer a latch.
    int idx;
    idx        = 0;
    w_grant    = '0;
    w_grant_id = '0;
    w_issue    = 1'b0;
    if (!reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(r_ptr) + k) % NUM_REQ;
        if (!w_issue && w_elig[ID_W'(idx)]) begin
          w_issue              = 1'b1;
          w_grant_id           = ID_W'(idx);
          w_grant[ID_W'(idx)]  = 1'b1;
        end
      end
    end
  end

  // The engine must be clocked on every edge where an op is presented or
  // still has a stage to advance; the last stage is already at the output.
  always_comb begin
    w_upstream = 1'b0;
    for (int s = 0; s < LATENCY - 1; s++) begin
      w_upstream = w_upstream | r_stg_vld[s];
    end
  end

  // One-hot decode of the requester whose result is on eng_result now.
  always_comb begin
    w_complete = '0;
    if (w_done) begin
      w_complete[w_done_id] = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign req_ready  = w_grant;
  assign eng_angle  = w_issue ? w_angles[w_grant_id] : 32'h0;
  assign eng_clk_en = !reset && (w_issue || w_upstream);
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign busy       = !reset && (|r_outstanding);

  // -------------------------------------------------------------------------
  // Round-robin pointer: moves just past the winner, holds when idle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_ptr <= '0;
    end else if (w_issue) begin
      r_ptr <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // In-flight tag pipeline, mirrors the engine's register boundaries.
  // Advances every cycle; a bubble enters when nothing is issued.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stg_vld <= '0;
      r_stg_id  <= '0;
    end else begin
      for (int s = LATENCY - 1; s > 0; s--) begin
        r_stg_vld[s] <= r_stg_vld[s-1];
        r_stg_id[s]  <= r_stg_id[s-1];
      end
      r_stg_vld[0] <= w_issue;
      r_stg_id[0]  <= w_grant_id;
    end
  end

  // -------------------------------------------------------------------------
  // Outstanding flags and response buffers. A requester is outstanding from
  // issue until its response is consumed, so a buffer can never be written
  // while full and completion/consumption never hit the same index.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outstanding <= '0;
      r_resp_valid  <= '0;
    end else begin
      r_outstanding <= (r_outstanding | w_grant) & ~w_consume;
      r_resp_valid  <= (r_resp_valid & ~w_consume) | w_complete;
    end
  end

  // NOTE: the response data array is reset on purpose: resp_data is a
  // visible output that must read zero after reset, not a scratch memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_data <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_complete[i]) begin
          r_resp_data[i] <= eng_result;
        end
      end
    end
  end

`ifdef COS_ARB_STATS_EN
  // -------------------------------------------------------------------------
  // Statistics: grants issued, and cycles where work was waiting but nothing
  // could be issued. Both wrap at 2^32.
  // -------------------------------------------------------------------------
  logic [31:0] r_stat_issued;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_issued <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_issue) begin
        r_stat_issued <= r_stat_issued + 32'd1;
      end
      if ((|req_valid) && !w_issue) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  assign stat_issued = r_stat_issued;
  assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_cos_engine_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cos_engine_arbiter
//
// Drives cos_engine_arbiter (NUM_REQ=4, LATENCY=2) against a small two-stage
// engine stand-in that maps the four test angles to their float32 cosines and
// any other angle to its bitwise inverse. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_cos_engine_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LATENCY = 2;

  localparam logic [31:0] A_ZERO  = 32'h00000000;
  localparam logic [31:0] A_PI3   = 32'h3F860A92;
  localparam logic [31:0] A_PI2   = 32'h3FC90FDB;
  localparam logic [31:0] A_PI    = 32'h40490FDB;
  localparam logic [31:0] C_ONE   = 32'h3F800000;
  localparam logic [31:0] C_HALF  = 32'h3F000000;
  localparam logic [31:0] C_TINY  = 32'hB33BBD2E;
  localparam logic [31:0] C_MONE  = 32'hBF800000;

  logic                  clk;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_angle;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [32*NUM_REQ-1:0] resp_data;
  logic [NUM_REQ-1:0]    resp_ready;
  logic                  eng_clk_en;
  logic [31:0]           eng_angle;
  logic [31:0]           eng_result;
  logic                  busy;
`ifdef COS_ARB_STATS_EN
  logic [31:0]           stat_issued;
  logic [31:0]           stat_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cos_engine_arbiter #(
    .NUM_REQ (NUM_REQ),
    .LATENCY (LATENCY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_angle   (req_angle),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_ready  (resp_ready),
    .eng_clk_en  (eng_clk_en),
    .eng_angle   (eng_angle),
    .eng_result  (eng_result),
`ifdef COS_ARB_STATS_EN
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall),
`endif
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine stand-in: two register stages, flushed whenever clk_en is low.
  function automatic logic [31:0] cos_ref(input logic [31:0] a);
    case (a)
      A_ZERO:  return C_ONE;
      A_PI3:   return C_HALF;
      A_PI2:   return C_TINY;
      A_PI:    return C_MONE;
      default: return ~a;
    endcase
  endfunction

  logic [31:0] eng_s0, eng_s1;
  always @(posedge clk) begin
    if (!eng_clk_en) begin
      eng_s0 <= 32'h0;
      eng_s1 <= 32'h0;
    end else begin
      eng_s0 <= eng_angle;
      eng_s1 <= cos_ref(eng_s0);
    end
  end
  assign eng_result = eng_s1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = '1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] slice(input logic [32*NUM_REQ-1:0] v, input int i);
    return v[i*32 +: 32];
  endfunction

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [3:0]  rr;
    logic [3:0]  e_ready;
    logic        e_clk_en;
    logic [31:0] e_angle;
    logic [3:0]  e_rvalid;
    logic        e_busy;
  } vec_t;

  vec_t        vecs [17];
  logic [31:0] exp_cos [4];

  initial begin
    exp_cos[0] = C_ONE;
    exp_cos[1] = C_HALF;
    exp_cos[2] = C_TINY;
    exp_cos[3] = C_MONE;

    //            rst   rv     rr     ready  clk   angle   rvalid busy
    vecs[0]  = '{1'b1, 4'h0, 4'hF, 4'h0, 1'b0, A_ZERO, 4'h0, 1'b0};
    vecs[1]  = '{1'b0, 4'h0, 4'hF, 4'h0, 1'b0, A_ZERO, 4'h0, 1'b0};
    // requester 0 alone, angle 0
    vecs[2]  = '{1'b0, 4'h1, 4'hF, 4'h1, 1'b1, A_ZERO, 4'h0, 1'b0};
    vecs[3]  = '{1'b0, 4'h0, 4'hF, 4'h0, 1'b1, A_ZERO, 4'h0, 1'b1};
    vecs[4]  = '{1'b0, 4'h0, 4'hF, 4'h0, 1'b0, A_ZERO, 4'h0, 1'b1};
    vecs[5]  = '{1'b0, 4'h0, 4'hF, 4'h0, 1'b0, A_ZERO, 4'h1, 1'b1};
    vecs[6]  = '{1'b0, 4'h0, 4'hF, 4'h0, 1'b0, A_ZERO, 4'h0, 1'b0};
    // reset to bring the pointer back to 0
    vecs[7]  = '{1'b1, 4'h0, 4'hF, 4'h0, 1'b0, A_ZERO, 4'h0, 1'b0};
    vecs[8]  = '{1'b0, 4'h0, 4'hF, 4'h0, 1'b0, A_ZERO, 4'h0, 1'b0};
    // all four at once; each drops valid after its grant
    vecs[9]  = '{1'b0, 4'hF, 4'hF, 4'h1, 1'b1, A_ZERO, 4'h0, 1'b0};
    vecs[10] = '{1'b0, 4'hE, 4'hF, 4'h2, 1'b1, A_PI3,  4'h0, 1'b1};
    vecs[11] = '{1'b0, 4'hC, 4'hF, 4'h4, 1'b1, A_PI2,  4'h0, 1'b1};
    vecs[12] = '{1'b0, 4'h8, 4'hF, 4'h8, 1'b1, A_PI,   4'h1, 1'b1};
    vecs[13] = '{1'b0, 4'h0, 4'hF, 4'h0, 1'b1, A_ZERO, 4'h2, 1'b1};
    vecs[14] = '{1'b0, 4'h0, 4'hF, 4'h0, 1'b0, A_ZERO, 4'h4, 1'b1};
    vecs[15] = '{1'b0, 4'h0, 4'hF, 4'h0, 1'b0, A_ZERO, 4'h8, 1'b1};
    vecs[16] = '{1'b0, 4'h0, 4'hF, 4'h0, 1'b0, A_ZERO, 4'h0, 1'b0};

    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = '1;
    req_angle  = {A_PI, A_PI2, A_PI3, A_ZERO};
    tick();

    // ---------------- table-driven: single requester + four-way ----------
    for (int n = 0; n < 17; n++) begin
      reset      = vecs[n].rst;
      req_valid  = vecs[n].rv;
      resp_ready = vecs[n].rr;
      #2;
      check($sformatf("v%0d req_ready", n), 32'(req_ready), 32'(vecs[n].e_ready));
      check($sformatf("v%0d eng_clk_en", n), 32'(eng_clk_en), 32'(vecs[n].e_clk_en));
      check($sformatf("v%0d eng_angle", n), eng_angle, vecs[n].e_angle);
      if (!vecs[n].rst) begin
        check($sformatf("v%0d resp_valid", n), 32'(resp_valid), 32'(vecs[n].e_rvalid));
        check($sformatf("v%0d busy", n), 32'(busy), 32'(vecs[n].e_busy));
        for (int i = 0; i < NUM_REQ; i++) begin
          if (vecs[n].e_rvalid[i[1:0]]) begin
            check($sformatf("v%0d resp_data[%0d]", n, i), slice(resp_data, i), exp_cos[i]);
          end
        end
      end
      tick();
    end

`ifdef COS_ARB_STATS_EN
    check("stats issued after 4-way", stat_issued, 32'd4);
    check("stats stall after 4-way", stat_stall, 32'd0);
`endif

    // ---------------- requester 1 held off while requester 2 streams -----
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      logic [3:0] e_ready;
      req_valid  = 4'b0110;
      resp_ready = (c >= 13) ? 4'b1111 : 4'b1101;
      #2;
      if (c == 0 || c == 14)  e_ready = 4'b0010;
      else if ((c % 4) == 1)  e_ready = 4'b0100;
      else                    e_ready = 4'b0000;
      check($sformatf("hold c%0d req_ready", c), 32'(req_ready), 32'(e_ready));
      check($sformatf("hold c%0d resp_valid[1]", c), 32'(resp_valid[1]),
            32'(c >= 3 && c <= 13));
      check($sformatf("hold c%0d resp_valid[2]", c), 32'(resp_valid[2]),
            32'(c >= 4 && (c % 4) == 0));
      if (c >= 3 && c <= 13) begin
        check($sformatf("hold c%0d resp_data[1]", c), slice(resp_data, 1), C_HALF);
      end
      if (c >= 4 && (c % 4) == 0) begin
        check($sformatf("hold c%0d resp_data[2]", c), slice(resp_data, 2), C_TINY);
      end
      tick();
    end
    req_valid = '0;

    // ---------------- pointer fairness: pointer at 2, requesters 0 and 3 --
    do_reset();
    req_valid = 4'b0010;
    #2;
    check("rr grant 1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b1001;
    #2;
    check("rr grant 3 first", 32'(req_ready), 32'h8);
    check("rr angle 3", eng_angle, A_PI);
    tick();
    req_valid = 4'b0001;
    #2;
    check("rr grant 0 next", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;

    // ---------------- reset one cycle after an issue ----------------------
    do_reset();
    req_valid = 4'b0001;
    #2;
    check("rst issue ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    reset     = 1'b1;
    #2;
    check("rst in reset req_ready", 32'(req_ready), 32'h0);
    check("rst in reset clk_en", 32'(eng_clk_en), 32'h0);
    check("rst in reset eng_angle", eng_angle, 32'h0);
    tick();
    #2;
    check("rst after edge resp_valid", 32'(resp_valid), 32'h0);
    check("rst after edge busy", 32'(busy), 32'h0);
    check("rst after edge clk_en", 32'(eng_clk_en), 32'h0);
    check("rst resp_data[0]", slice(resp_data, 0), 32'h0);
    check("rst resp_data[3]", slice(resp_data, 3), 32'h0);
    reset = 1'b0;
    tick();
    for (int c = 0; c < 6; c++) begin
      #2;
      check($sformatf("rst drop c%0d resp_valid", c), 32'(resp_valid), 32'h0);
      check($sformatf("rst drop c%0d clk_en", c), 32'(eng_clk_en), 32'h0);
      check($sformatf("rst drop c%0d busy", c), 32'(busy), 32'h0);
      tick();
    end

`ifdef COS_ARB_STATS_EN
    // ---------------- blocked requester counts stalls ---------------------
    do_reset();
    req_valid  = 4'b0001;
    resp_ready = 4'b0000;
    tick();
    for (int c = 0; c < 8; c++) begin
      tick();
    end
    #2;
    check("stats issued blocked", stat_issued, 32'd1);
    check("stats stall blocked", stat_stall, 32'd8);
    req_valid  = '0;
    resp_ready = '1;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cos_engine_arbiter.md
Name: cos_engine_arbiter

Overview:
- Shares one pipelined cosine engine (float32 angle in, float32 cosine out, fixed LATENCY-cycle pipeline, clk_en low flushes its stage registers) among NUM_REQ requesters.
- Round-robin issue of at most one angle per cycle; each request is tagged with its requester ID; the returning result is routed to that requester's one-entry response buffer.
- Drives the engine's clk_en: high only while work is issued or in flight.
- Sits between the custom-instruction/bus front ends and the cosine datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LATENCY, 2, cycles from angle presented (clk_en high) to result valid on eng_result; must match the engine's register-boundary count.
- ID_W, $clog2(NUM_REQ), width of the internal tag.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  request present, per requester
- req_angle  in  32*NUM_REQ  float32 angle, slice i for requester i
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- resp_valid  out  NUM_REQ  response buffer i holds a result
- resp_data  out  32*NUM_REQ  float32 cosine, slice i
- resp_ready  in  NUM_REQ  requester i consumes its response
- eng_clk_en  out  1  engine clock enable
- eng_angle  out  32  angle to engine (combinational from grant)
- eng_result  in  32  engine result
- busy  out  1  any requester outstanding

Behaviour:
- Reset: req_ready=0, resp_valid=0, resp_data=0, eng_clk_en=0, eng_angle=0, busy=0; in-flight shift register cleared, outstanding flags cleared, RR pointer=0. Reset mid-operation drops all in-flight and buffered results; nothing is returned for them.
- Eligibility: requester i eligible iff req_valid[i] & !outstanding[i]. outstanding[i] is set on issue and cleared on the cycle resp_valid[i]&resp_ready[i]. Hence at most one op per requester in flight or buffered, and a response buffer can never overflow.
- Arbitration: round-robin starting at pointer p. Grant the first eligible index scanning p, p+1, ... (mod NUM_REQ). On grant g, the pointer becomes (g+1) mod NUM_REQ. With no grant, the pointer holds.
- Issue cycle t:
  - req_ready[g]=1 and eng_angle=req_angle slice g, in the same cycle (combinational).
  - Tag {1,g} enters in-flight stage 0.
  - With no grant, eng_angle=0 and a bubble enters.
- In-flight tracker: LATENCY-deep shift register of {valid, ID}, advancing every cycle. eng_clk_en = issue | (|valid of all stages except last). The engine therefore sees clk_en high at every edge an op needs to advance. eng_clk_en is 0 when idle.
- Completion: when the last stage is valid (cycle t+LATENCY), capture eng_result into resp_data slice ID and set resp_valid[ID] on the next edge. The response is visible at t+LATENCY+1. Total request-to-response latency is LATENCY+1 cycles.
- Response hold: resp_valid/resp_data are stable until resp_ready. Consumption clears resp_valid[i] and outstanding[i] at the edge. The requester may re-issue in the cycle after consumption; same-cycle reissue is not allowed.
- Simultaneous events:
  - Completion for i and consumption for j≠i in the same cycle are both applied.
  - Completion for i and consumption for i in the same cycle cannot occur, by the outstanding rule.
- Throughput: 1 op/cycle aggregate when ≥LATENCY+2 requesters have work. A single requester gets 1 op per LATENCY+2 cycles with resp_ready tied high.
- busy = |outstanding.
- No arithmetic on data; angle and result pass through bit-exact.

Optional Feature:
- Macro: COS_ARB_STATS_EN.
- Defined:
  - Adds output stat_issued (32 bits), counting grants, wrapping at 2^32.
  - Adds output stat_stall (32 bits), counting cycles with any req_valid high but no grant.
  - Both counters reset to 0.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- Requester 0 alone, angle 32'h00000000, resp_ready=1:
  - req_ready[0] in the issue cycle.
  - eng_clk_en high for cycles t..t+LATENCY-1.
  - resp_valid[0] at t+3 with data 32'h3F800000 (±2 LSB with the real engine).
  - eng_clk_en returns to 0.
- All 4 requesters valid at once, angles 0, pi/3 (32'h3F860A92), pi/2 (32'h3FC90FDB), pi (32'h40490FDB):
  - Grants occur in order 0,1,2,3 on consecutive cycles.
  - Responses arrive at t+3..t+6, routed to the correct IDs.
  - Values are ≈1.0, 0.5, ≈0, -1.0 (32'hBF800000), within tolerance.
- Requester 1 holds resp_ready=0 for 10 cycles while requester 2 streams:
  - req_ready[1] stays 0 and resp_data[1] stays stable.
  - Requester 2 is unaffected.
  - After resp_ready[1] is asserted, requester 1 is re-granted no earlier than the next cycle.
- Pointer fairness: pointer at 2 with requesters 0 and 3 valid -> grant 3 first, then 0.
- Reset asserted one cycle after an issue:
  - All outputs return to reset values.
  - No resp_valid for the dropped op after reset deasserts.
  - eng_clk_en=0 during reset.
- With COS_ARB_STATS_EN defined, after the 4-request scenario: stat_issued=4 and stat_stall=0. A blocked requester with a full buffer and no other work increments stat_stall once per cycle.
